mio_arbiter: RTL

MIO_ARBITER -- requirements
Module: mio_arbiter

---
 rtl/mio_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mio_arbiter.sv
`default_nettype none
// ============================================================================
// mio_arbiter : two-requester (CPU / DMA) memory-I/O arbiter with a
//               fixed-latency IDLE -> ACC -> RESP access sequencer.
// Option      : define MIO_ARB_RR_EN for round-robin arbitration; when it is
//               undefined the CPU has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ack,
   output logic [31:0] rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        gnt_dma,
   output logic [1:0]  state_out
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_l_q, mem_we_l_d;
   logic        gnt_dma_q, gnt_dma_d;
   logic        grant_dma;
   logic        any_req;

   assign any_req = cpu_req | dma_req;

`ifdef MIO_ARB_RR_EN
   // Resets to "DMA granted last" so the CPU wins the first contest.
   logic last_dma_q, last_dma_d;

   always_comb begin
      grant_dma = dma_req & (~cpu_req | ~last_dma_q);
   end

   always_comb begin
      last_dma_d = last_dma_q;
      if ((state_q == IDLE) && any_req) begin
         last_dma_d = grant_dma;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_dma_q <= 1'b1;
      end else begin
         last_dma_q <= last_dma_d;
      end
   end
`else
   always_comb begin
      grant_dma = dma_req & ~cpu_req;
   end
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_l_d  = mem_we_l_q;
      gnt_dma_d   = gnt_dma_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = ACC;
               cnt_d       = 4'd0;
               gnt_dma_d   = grant_dma;
               mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
               mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
               mem_we_l_d  = grant_dma ? dma_we    : cpu_we;
            end
         end
         ACC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_LAST) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rdata_q     <= 32'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_we_l_q  <= 1'b0;
         gnt_dma_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_l_q  <= mem_we_l_d;
         gnt_dma_q   <= gnt_dma_d;
      end
   end

   // Strobes are gated by reset so they drop the instant reset rises.
   assign mem_en    = ~reset & (state_q == ACC);
   assign mem_we    = ~reset & (state_q == ACC) & (cnt_q == 4'd0) & mem_we_l_q;
   assign cpu_ready = ~reset & (state_q == RESP) & ~gnt_dma_q;
   assign dma_ack   = ~reset & (state_q == RESP) & gnt_dma_q;

   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign gnt_dma   = gnt_dma_q;
   assign state_out = state_q;

endmodule
`default_nettype wire
